// File: rtl/axis_data_packer_param.sv
// AXI-Stream width packer: gathers 1..MAX_RATIO narrow beats into one wide word with tkeep/tlast.
// Build option DATA_PACKER_MSB_FIRST_EN places the first beat in the top lane (left-justified words).
module axis_data_packer_param #(
    parameter int IN_WIDTH  = 8,
    parameter int MAX_RATIO = 8,
    parameter int CFG_WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [CFG_WIDTH-1:0]          confi,
    input  logic [IN_WIDTH-1:0]           s_axis_tdata,
    input  logic                          s_axis_tvalid,
    output logic                          s_axis_tready,
    input  logic                          s_axis_tlast,
    output logic [IN_WIDTH*MAX_RATIO-1:0] m_axis_tdata,
    output logic [MAX_RATIO-1:0]          m_axis_tkeep,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          m_axis_tlast,
    output logic                          cfg_err
);
    localparam int HALF = CFG_WIDTH / 2;
    localparam int LCW  = $clog2(MAX_RATIO + 1);

    localparam logic [0:0] ST_FILL = 1'b0;
    localparam logic [0:0] ST_FULL = 1'b1;

    typedef logic [MAX_RATIO-1:0][IN_WIDTH-1:0] word_t;

    logic [0:0]           state_q, state_d;
    word_t                acc_q, acc_d, merged;
    logic [MAX_RATIO-1:0] acc_keep_q, acc_keep_d, merged_keep, lane_hit;
    logic                 acc_last_q, acc_last_d;
    logic [LCW-1:0]       lane_q, lane_d, lane_nxt;
    logic [LCW-1:0]       ratio_q, ratio_d, eff_ratio, clamp_ratio;
    logic [HALF-1:0]      raw_ratio, len_q, len_d, eff_len;
    logic [HALF-1:0]      pkt_cnt_q, pkt_cnt_d, pkt_nxt;
    logic                 pkt_act_q, pkt_act_d;
    word_t                out_data_q, out_data_d;
    logic [MAX_RATIO-1:0] out_keep_q, out_keep_d;
    logic                 out_valid_q, out_valid_d, out_last_q, out_last_d;
    logic                 err_q, err_d;
    logic                 rdy_en_q;
    logic                 accept, out_free, out_drain, first_beat, ratio_bad;
    logic                 len_hit, beat_last, beat_done;

    assign s_axis_tready = rdy_en_q & (state_q == ST_FILL);
    assign accept        = s_axis_tvalid & s_axis_tready;
    assign out_drain     = out_valid_q & m_axis_tready;
    assign out_free      = ~out_valid_q | m_axis_tready;

    // Config is only taken from confi on the first beat of a packet; later beats use the latched copy.
    assign first_beat  = ~pkt_act_q;
    assign raw_ratio   = confi[CFG_WIDTH-1:HALF];
    assign ratio_bad   = raw_ratio > HALF'(MAX_RATIO);
    assign clamp_ratio = (raw_ratio == '0) ? LCW'(1) :
                         ratio_bad         ? LCW'(MAX_RATIO) : LCW'(raw_ratio);
    assign eff_ratio   = first_beat ? clamp_ratio : ratio_q;
    assign eff_len     = first_beat ? confi[HALF-1:0] : len_q;

    assign lane_nxt  = lane_q + LCW'(1);
    assign pkt_nxt   = pkt_cnt_q + HALF'(1);
    assign len_hit   = (eff_len != '0) && (pkt_nxt == eff_len);
    assign beat_last = s_axis_tlast | len_hit;
    assign beat_done = (lane_nxt == eff_ratio) | beat_last;

    for (genvar i = 0; i < MAX_RATIO; i++) begin : g_lane
`ifdef DATA_PACKER_MSB_FIRST_EN
        localparam int BEAT = MAX_RATIO - 1 - i;
`else
        localparam int BEAT = i;
`endif
        assign lane_hit[i]    = (lane_q == LCW'(BEAT));
        assign merged[i]      = lane_hit[i] ? s_axis_tdata : acc_q[i];
        assign merged_keep[i] = lane_hit[i] | acc_keep_q[i];
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        acc_keep_d  = acc_keep_q;
        acc_last_d  = acc_last_q;
        lane_d      = lane_q;
        ratio_d     = ratio_q;
        len_d       = len_q;
        pkt_cnt_d   = pkt_cnt_q;
        pkt_act_d   = pkt_act_q;
        out_data_d  = out_data_q;
        out_keep_d  = out_keep_q;
        out_last_d  = out_last_q;
        out_valid_d = out_valid_q & ~m_axis_tready;
        err_d       = err_q;

        if (accept) begin
            if (first_beat) begin
                ratio_d = clamp_ratio;
                len_d   = confi[HALF-1:0];
                if (ratio_bad) err_d = 1'b1;
            end
            pkt_cnt_d = beat_last ? '0 : pkt_nxt;
            pkt_act_d = ~beat_last;
            if (beat_done) begin
                lane_d = '0;
                if (out_free) begin
                    // Completed word bypasses ACC straight into OUT.
                    out_data_d  = merged;
                    out_keep_d  = merged_keep;
                    out_last_d  = beat_last;
                    out_valid_d = 1'b1;
                    acc_d       = '0;
                    acc_keep_d  = '0;
                    acc_last_d  = 1'b0;
                end else begin
                    acc_d      = merged;
                    acc_keep_d = merged_keep;
                    acc_last_d = beat_last;
                    state_d    = ST_FULL;
                end
            end else begin
                acc_d      = merged;
                acc_keep_d = merged_keep;
                lane_d     = lane_nxt;
            end
        end

        if ((state_q == ST_FULL) && out_drain) begin
            out_data_d  = acc_q;
            out_keep_d  = acc_keep_q;
            out_last_d  = acc_last_q;
            out_valid_d = 1'b1;
            acc_d       = '0;
            acc_keep_d  = '0;
            acc_last_d  = 1'b0;
            state_d     = ST_FILL;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_FILL;
            acc_q       <= '0;
            acc_keep_q  <= '0;
            acc_last_q  <= 1'b0;
            lane_q      <= '0;
            ratio_q     <= LCW'(1);
            len_q       <= '0;
            pkt_cnt_q   <= '0;
            pkt_act_q   <= 1'b0;
            out_data_q  <= '0;
            out_keep_q  <= '0;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
            rdy_en_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            acc_keep_q  <= acc_keep_d;
            acc_last_q  <= acc_last_d;
            lane_q      <= lane_d;
            ratio_q     <= ratio_d;
            len_q       <= len_d;
            pkt_cnt_q   <= pkt_cnt_d;
            pkt_act_q   <= pkt_act_d;
            out_data_q  <= out_data_d;
            out_keep_q  <= out_keep_d;
            out_last_q  <= out_last_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
            rdy_en_q    <= 1'b1;
        end
    end

    assign m_axis_tdata  = out_data_q;
    assign m_axis_tkeep  = out_keep_q;
    assign m_axis_tvalid = out_valid_q;
    assign m_axis_tlast  = out_last_q;
    assign cfg_err       = err_q;

endmodule

// File: tb/tb_axis_data_packer_param.sv
// Bench for axis_data_packer_param: directed test-plan scenarios plus random traffic vs a packet-level model.
module tb_axis_data_packer_param;
    localparam int IW = 8;
    localparam int MR = 8;
    localparam int CW = 16;
    localparam int OW = IW * MR;

    typedef struct { logic [OW-1:0] d; logic [MR-1:0] k; logic l; } word_t;

    logic          clk = 1'b0, rst_n = 1'b1;
    logic [CW-1:0] confi = '0;
    logic [IW-1:0] s_tdata = '0;
    logic          s_tvalid = 1'b0, s_tlast = 1'b0, s_tready;
    logic [OW-1:0] m_tdata;
    logic [MR-1:0] m_tkeep;
    logic          m_tvalid, m_tlast, cfg_err;
    logic          m_ready = 1'b0;
    bit            rdy_force = 1'b1, rdy_rand = 1'b0, mon_en = 1'b0;

    int n_chk = 0, n_err = 0;

    // reference model state
    word_t         exp_q[$];
    logic [IW-1:0] mb[$];
    int            m_r = 1, m_l = 0, m_pcnt = 0, n_words = 0;
    bit            m_inpkt = 1'b0, exp_err = 1'b0;
    bit            prev_stall = 1'b0;
    logic [OW-1:0] prev_d, last_d;
    logic [MR-1:0] prev_k, last_k;
    logic          prev_l, last_l;
    word_t         mon_w;

    axis_data_packer_param #(.IN_WIDTH(IW), .MAX_RATIO(MR), .CFG_WIDTH(CW)) dut (
        .clk(clk), .reset_n(rst_n), .confi(confi),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .s_axis_tlast(s_tlast),
        .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tvalid(m_tvalid),
        .m_axis_tready(m_ready), .m_axis_tlast(m_tlast), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #2;
        m_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_force;
    end

    task automatic chk(input string tag, input logic [OW-1:0] got, input logic [OW-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int lane_of(input int k);
`ifdef DATA_PACKER_MSB_FIRST_EN
        return MR - 1 - k;
`else
        return k;
`endif
    endfunction

    // Builds an expected word from a list of beats given in arrival order.
    function automatic word_t mk_word(input logic [IW-1:0] b[$], input logic l);
        word_t w;
        w.d = '0; w.k = '0; w.l = l;
        foreach (b[k]) begin
            w.d[lane_of(k)*IW +: IW] = b[k];
            w.k[lane_of(k)] = 1'b1;
        end
        return w;
    endfunction

    task automatic model_beat(input logic [IW-1:0] d, input logic l);
        bit lst;
        if (mb.size() == 0 && !m_inpkt) begin
            m_r = int'(confi[15:8]);
            m_l = int'(confi[7:0]);
            if (m_r == 0) m_r = 1;
            if (m_r > MR) begin m_r = MR; exp_err = 1'b1; end
        end
        mb.push_back(d);
        m_pcnt++;
        lst = l || (m_l != 0 && m_pcnt == m_l);
        if (lst || mb.size() == m_r) begin
            exp_q.push_back(mk_word(mb, lst));
            mb.delete();
        end
        if (lst) begin m_pcnt = 0; m_inpkt = 1'b0; end
        else m_inpkt = 1'b1;
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete(); mb.delete();
            m_pcnt = 0; m_inpkt = 1'b0; exp_err = 1'b0; prev_stall = 1'b0;
        end else if (mon_en) begin
            chk("cfg_err", OW'(cfg_err), OW'(exp_err));
            if (prev_stall) begin
                chk("hold_valid", OW'(m_tvalid), OW'(1));
                chk("hold_data", m_tdata, prev_d);
                chk("hold_keep", OW'(m_tkeep), OW'(prev_k));
                chk("hold_last", OW'(m_tlast), OW'(prev_l));
            end
            if (s_tvalid && s_tready) model_beat(s_tdata, s_tlast);
            if (m_tvalid && m_ready) begin
                if (exp_q.size() == 0) chk("spurious_word", OW'(exp_q.size()), OW'(1));
                else begin
                    mon_w = exp_q.pop_front();
                    chk("word_data", m_tdata, mon_w.d);
                    chk("word_keep", OW'(m_tkeep), OW'(mon_w.k));
                    chk("word_last", OW'(m_tlast), OW'(mon_w.l));
                end
                last_d = m_tdata; last_k = m_tkeep; last_l = m_tlast;
                n_words++;
            end
            prev_stall = m_tvalid && !m_ready;
            prev_d = m_tdata; prev_k = m_tkeep; prev_l = m_tlast;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [IW-1:0] d, input logic l);
        int t = 0;
        bit ok = 1'b0;
        s_tdata = d; s_tlast = l; s_tvalid = 1'b1;
        while (!ok && t < 500) begin
            @(negedge clk);
            t++;
            if (s_tready) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        if (!ok) chk("send_timeout", OW'(ok), OW'(1));
        s_tvalid = 1'b0; s_tlast = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b0; mon_en = 1'b1; s_tvalid = 1'b0; s_tlast = 1'b0;
        #1;
        chk("rst_tready", OW'(s_tready), OW'(0));
        chk("rst_mvalid", OW'(m_tvalid), OW'(0));
        chk("rst_tdata", m_tdata, OW'(0));
        chk("rst_tkeep", OW'(m_tkeep), OW'(0));
        chk("rst_tlast", OW'(m_tlast), OW'(0));
        chk("rst_cfgerr", OW'(cfg_err), OW'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rel_tready", OW'(s_tready), OW'(0));
        idle(1);
        chk("tready_up", OW'(s_tready), OW'(1));
    endtask

    task automatic drain();
        int t = 0;
        while ((exp_q.size() != 0 || m_tvalid) && t < 3000) begin idle(1); t++; end
        chk("drain_left", OW'(exp_q.size()), OW'(0));
    endtask

    function automatic logic [OW-1:0] dw(input logic [IW-1:0] b[$]);
        word_t w = mk_word(b, 1'b0);
        return w.d;
    endfunction

    function automatic logic [MR-1:0] kw(input int n);
        logic [IW-1:0] b[$];
        word_t w;
        for (int i = 0; i < n; i++) b.push_back('0);
        w = mk_word(b, 1'b0);
        return w.k;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;
        rdy_force = 1'b1;
        do_reset();

        // four beats, ratio 4, no tlast
        confi = 16'h0400;
        send_beat(8'h02, 1'b0); send_beat(8'h03, 1'b0); send_beat(8'h04, 1'b0);
        chk("t1_early_valid", OW'(m_tvalid), OW'(0));
        send_beat(8'h05, 1'b0);
        chk("t1_valid", OW'(m_tvalid), OW'(1));
        chk("t1_data", m_tdata, dw('{8'h02, 8'h03, 8'h04, 8'h05}));
        chk("t1_keep", OW'(m_tkeep), OW'(kw(4)));
        chk("t1_last", OW'(m_tlast), OW'(0));
        idle(2);
        do_reset();

        // packet length 16 with ratio 4; the following beat starts a fresh word
        confi = 16'h0410;
        w0 = n_words;
        for (int i = 1; i <= 16; i++) send_beat(8'(i), 1'b0);
        idle(3);
        chk("t2_words", OW'(n_words - w0), OW'(4));
        chk("t2_data", last_d, dw('{8'h0D, 8'h0E, 8'h0F, 8'h10}));
        chk("t2_last", OW'(last_l), OW'(1));
        for (int i = 17; i <= 20; i++) send_beat(8'(i), 1'b0);
        idle(3);
        chk("t2_next_data", last_d, dw('{8'h11, 8'h12, 8'h13, 8'h14}));
        chk("t2_next_last", OW'(last_l), OW'(0));
        do_reset();

        // early flush on tlast
        confi = 16'h0400;
        send_beat(8'h07, 1'b0); send_beat(8'h08, 1'b0); send_beat(8'h09, 1'b1);
        idle(3);
        chk("t3_data", last_d, dw('{8'h07, 8'h08, 8'h09}));
        chk("t3_keep", OW'(last_k), OW'(kw(3)));
        chk("t3_last", OW'(last_l), OW'(1));
        do_reset();

        // output stalled: second word parks in ACC and input back-pressures
        confi = 16'h0400;
        rdy_force = 1'b0;
        w0 = n_words;
        for (int i = 0; i < 8; i++) send_beat(8'(8'h11 + i), 1'b0);
        chk("t4_full_tready", OW'(s_tready), OW'(0));
        chk("t4_hold_data", m_tdata, dw('{8'h11, 8'h12, 8'h13, 8'h14}));
        idle(3);
        chk("t4_still_full", OW'(s_tready), OW'(0));
        rdy_force = 1'b1;
        drain();
        chk("t4_words", OW'(n_words - w0), OW'(2));
        chk("t4_second", last_d, dw('{8'h15, 8'h16, 8'h17, 8'h18}));
        do_reset();

        // ratio clamp and sticky cfg_err, then ratio 0 -> 1
        confi = 16'h0C00;
        w0 = n_words;
        send_beat(8'h21, 1'b0);
        chk("t5_err_set", OW'(cfg_err), OW'(1));
        for (int i = 1; i < 8; i++) send_beat(8'(8'h21 + i), i == 7);
        idle(3);
        chk("t5_clamp_keep", OW'(last_k), OW'(kw(8)));
        confi = 16'h0000;
        send_beat(8'h31, 1'b0); send_beat(8'h32, 1'b0); send_beat(8'h33, 1'b1);
        idle(3);
        chk("t5_words", OW'(n_words - w0), OW'(4));
        chk("t5_r1_keep", OW'(last_k), OW'(kw(1)));
        chk("t5_r1_data", last_d, dw('{8'h33}));
        chk("t5_err_sticky", OW'(cfg_err), OW'(1));

        // reset with a held word and a partial word in flight
        confi = 16'h0400;
        rdy_force = 1'b0;
        for (int i = 0; i < 6; i++) send_beat(8'(8'h41 + i), 1'b0);
        chk("t6_pre_valid", OW'(m_tvalid), OW'(1));
        do_reset();
        rdy_force = 1'b1;
        w0 = n_words;
        for (int i = 0; i < 4; i++) send_beat(8'(8'h51 + i), 1'b0);
        idle(3);
        chk("t6_words", OW'(n_words - w0), OW'(1));
        chk("t6_data", last_d, dw('{8'h51, 8'h52, 8'h53, 8'h54}));
        chk("t6_keep", OW'(last_k), OW'(kw(4)));
        do_reset();

        // random traffic, random back-pressure, config churn mid-packet
        rdy_rand = 1'b1;
        for (int p = 0; p < 60; p++) begin
            int len = $urandom_range(1, 12);
            confi = {8'($urandom_range(0, 10)), 8'($urandom_range(0, 6))};
            for (int b = 0; b < len; b++) begin
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
                send_beat(8'($urandom), b == len - 1);
                if ($urandom_range(0, 4) == 0)
                    confi = {8'($urandom_range(0, 10)), 8'($urandom_range(0, 6))};
            end
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/axis_data_packer_param.md
Name: axis_data_packer_param

Overview:
Parametrised AXI-Stream width packer that gathers 1..MAX_RATIO narrow input beats into one wide output word. The pack ratio and packet length are runtime-configurable.
- Byte-lane valid flags on the output.
- Early-flush of partial words on input tlast or on a packet-length boundary.
- One-deep accumulate-while-hold buffering, so full throughput is kept while the output is being drained.
- Sits between narrow sample sources and wide DMA/stream sinks.

Parameters:
IN_WIDTH, 8, width of one input beat (lane width)
MAX_RATIO, 8, maximum number of input beats packed per output word (number of lanes)
CFG_WIDTH, 16, width of confi

Ports:
clk  in  1  system clock; all logic rising-edge
reset_n  in  1  asynchronous active-low reset
confi  in  CFG_WIDTH  [15:8] pack ratio R; [7:0] packet length L in input beats (0 = no auto-last)
s_axis_tdata  in  IN_WIDTH  input beat
s_axis_tvalid  in  1  input valid
s_axis_tready  out  1  input ready
s_axis_tlast  in  1  input end-of-packet
m_axis_tdata  out  IN_WIDTH*MAX_RATIO  packed word
m_axis_tkeep  out  MAX_RATIO  one bit per filled lane
m_axis_tvalid  out  1  output valid
m_axis_tready  in  1  output ready
m_axis_tlast  out  1  output end-of-packet
cfg_err  out  1  sticky: illegal ratio was sampled

Behaviour:
- Reset (async assert, sync release): all outputs 0, including s_axis_tready. Accumulator, lane counter and packet counter are cleared. cfg_err is cleared.
- s_axis_tready rises on the first clk edge after reset release.
- A reset mid-packet discards all partial data. The next beat starts at lane 0.
- Config sampling: confi is latched only when the accumulator is empty and no packet is in progress (first beat of a packet). Changes mid-packet are ignored until the next packet.
- Ratio rules:
  - R = 0 is treated as 1.
  - R > MAX_RATIO is clamped to MAX_RATIO and sets cfg_err.
- Lane order: beat k of a word goes to lane k, i.e. bits [k*IN_WIDTH +: IN_WIDTH]; the first beat is in the LSBs. Unfilled lanes are driven 0 and their tkeep bit is 0.
- A word completes on the accepted beat for which any of the following holds (whichever occurs first):
  - lane count reaches R;
  - s_axis_tlast = 1;
  - L != 0 and the packet beat count reaches L.
- m_axis_tlast = 1 when completion is due to s_axis_tlast or to L. On such completion the packet counter resets to 0.
- Storage: accumulator ACC plus output register OUT.
- State machine:
  - FILL: accepting beats into ACC. s_axis_tready = 1.
    - If a completing beat is accepted and OUT is empty or draining this cycle (m_axis_tvalid & m_axis_tready), ACC plus the beat move to OUT on the same edge.
    - Otherwise ACC holds the completed word → FULL.
  - FULL: s_axis_tready = 0. When OUT drains, ACC moves to OUT → FILL.
- Latency: m_axis_tvalid is high the cycle after the completing beat's handshake.
- Sustained throughput is 1 input beat per clk when m_axis_tready = 1.
- m_axis_tvalid/tdata/tkeep/tlast are held stable while m_axis_tvalid & !m_axis_tready (AXI rule). They must not change until the handshake completes.
- No combinational path from m_axis_tready to s_axis_tready beyond the FULL-state drain term.
- An input beat with s_axis_tvalid = 0 causes no change. Gaps mid-word are allowed indefinitely.
- R = 1: every beat produces a word with tkeep = 1.

Optional Feature:
- Macro: DATA_PACKER_MSB_FIRST_EN.
- Defined: beat k is placed in lane MAX_RATIO-1-k, so the first beat is in the MSBs and a partial word is left-justified. tkeep is mirrored accordingly.
- Undefined: LSB-first placement as above.
- All timing and handshake behaviour is identical in both builds.

Test Plan:
- IN_WIDTH 8, MAX_RATIO 8, confi 0x0400. Beats 0x02,0x03,0x04,0x05 → one word: tdata 0x0000_0000_0504_0302, tkeep 0x0F, tlast 0, valid 1 cycle after 4th handshake.
- confi 0x0410. Beats 0x01..0x10 → 4 words; last word tdata low 32 bits 0x100F0E0D, tlast 1. The 17th beat starts a new packet at lane 0.
- confi 0x0400. Beats 0x07,0x08,0x09 with tlast on 0x09 → tdata 0x090807, tkeep 0x07, tlast 1.
- confi 0x0400, m_axis_tready low for 7 cycles while 8 beats are offered → first word held stable, second word completes into ACC, s_axis_tready 0 until drain. All 8 beats arrive in order, none lost or duplicated.
- confi 0x0C00 → ratio clamped to 8, cfg_err 1 (sticky until reset). confi 0x0000 → ratio 1, each beat produces a word with tkeep 0x01.
- Assert reset_n low after 2 beats of a 4-beat word → outputs 0 immediately (asynchronous). After release, 4 new beats produce a word containing only the new data.
